// File: rtl/ddr_rd_arb_pkg.sv
// Shared definitions for the DDR read-port arbiter: FSM state encoding and
// the burst-length convention (an 8-bit length of 0 means 256 beats).
package ddr_rd_arb_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BEAT_W = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Number of beats a burst of the given length carries.
  function automatic logic [BEAT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker: returns the first requesting channel at or
// after ptr_i (wrapping), as a one-hot vector and as an index.
module rr_arbiter_onehot
  import ddr_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  logic [IDX_W:0] cand;

  // Walk the channels starting at the pointer; the first hit wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                     = 1'b1;
        idx_o                     = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_port_arbiter.sv
// Round-robin arbiter sharing the single DDR read port between NUM_CH
// requesters. One burst is in flight at a time; returned beats and the finish
// pulse are steered back to the owner. Optional watchdog under the macro
// DDR_RD_TIMEOUT_EN (timeout_o tied low when the macro is not defined).
module ddr_rd_port_arbiter
  import ddr_rd_arb_pkg::*;
#(
  parameter real         TCQ            = 0.1,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned MEM_DATA_BITS  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         ddr_clk_i,
  input  logic                         ddr_rst_n_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH*LEN_W-1:0]      ch_len_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
  output logic [NUM_CH-1:0]            ch_grant_o,
  output logic [NUM_CH-1:0]            ch_data_valid_o,
  output logic [MEM_DATA_BITS-1:0]     ch_data_o,
  output logic [NUM_CH-1:0]            ch_finish_o,
  output logic                         rd_ddr_req_o,
  output logic [LEN_W-1:0]             rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]        rd_ddr_addr_o,
  input  logic                         rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0]     rd_ddr_data_i,
  input  logic                         rd_ddr_finish_i,
  output logic                         len_err_o,
  output logic                         timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  // Reject parameter sets the datapath is not sized for. TCQ is a
  // simulation-only clock-to-q figure; registers here carry no delays.
  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 65535 || TCQ < 0.0) begin : g_cfg_check
    $error("ddr_rd_port_arbiter: unsupported parameter set");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                req_q, req_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [NUM_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                active;
  logic                beat_in;
  logic                timeout_hit;
  logic [BEAT_W:0]     beats_now;

  rr_arbiter_onehot #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req_i   (ch_req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // A burst is open in ISSUE and XFER; beats outside those states are dropped
  assign active    = (state_q == ISSUE) || (state_q == XFER);
  assign beat_in   = active && rd_ddr_data_valid_i;
  assign beats_now = {1'b0, beat_q} + (BEAT_W+1)'(beat_in);

`ifdef DDR_RD_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;

  // Watchdog: counts open-burst cycles without a beat, restarts on every beat
  always_comb begin
    wdog_d = '0;
    if (active && !rd_ddr_data_valid_i) wdog_d = wdog_q + 16'd1;
  end

  assign timeout_hit = active && !rd_ddr_data_valid_i && !rd_ddr_finish_i &&
                       (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) wdog_q <= '0;
    else              wdog_q <= wdog_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold the command until the first
  // beat or finish, close the burst and advance the round-robin pointer
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    req_d    = req_q;
    len_d    = len_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    if (beat_in && beat_q != '1) beat_d = beat_q + BEAT_W'(1);
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          grant_d = arb_grant;
          req_d   = 1'b1;
          len_d   = ch_len_i[arb_idx*LEN_W +: LEN_W];
          addr_d  = ch_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // finish takes priority over a same-cycle first beat
        if (rd_ddr_finish_i || timeout_hit) begin
          req_d   = 1'b0;
          grant_d = '0;
          state_d = RELEASE;
        end else if (rd_ddr_data_valid_i) begin
          req_d   = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (rd_ddr_finish_i || timeout_hit) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        rr_ptr_d = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + IDX_W'(1);
        beat_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst-context registers
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      req_q    <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      req_q    <= req_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
    end
  end

  assign ch_grant_o      = grant_q;
  assign rd_ddr_req_o    = req_q;
  assign rd_ddr_len_o    = len_q;
  assign rd_ddr_addr_o   = addr_q;
  assign ch_data_o       = rd_ddr_data_i;
  assign ch_data_valid_o = beat_in ? grant_q : '0;
  assign ch_finish_o     = (active && (rd_ddr_finish_i || timeout_hit)) ? grant_q : '0;
  assign len_err_o       = active && rd_ddr_finish_i &&
                           (beats_now != {1'b0, len_to_beats(len_q)});
  assign timeout_o       = timeout_hit;

endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// Scoreboard bench for ddr_rd_port_arbiter (NUM_CH=4, TIMEOUT_CYCLES=64).
module tb_ddr_rd_port_arbiter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    ch_req = '0;
  logic [31:0]   ch_len = '0;
  logic [119:0]  ch_addr = '0;
  logic [3:0]    ch_grant, ch_dv, ch_fin;
  logic [255:0]  ch_data;
  logic          rd_req;
  logic [7:0]    rd_len;
  logic [29:0]   rd_addr;
  logic          rd_valid = 1'b0;
  logic [255:0]  rd_data = '0;
  logic          rd_finish = 1'b0;
  logic          len_err, tmo;

  always #5 clk = ~clk;

  ddr_rd_port_arbiter #(
    .NUM_CH         (4),
    .ADDR_WIDTH     (30),
    .MEM_DATA_BITS  (256),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .ddr_clk_i           (clk),
    .ddr_rst_n_i         (rst_n),
    .ch_req_i            (ch_req),
    .ch_len_i            (ch_len),
    .ch_addr_i           (ch_addr),
    .ch_grant_o          (ch_grant),
    .ch_data_valid_o     (ch_dv),
    .ch_data_o           (ch_data),
    .ch_finish_o         (ch_fin),
    .rd_ddr_req_o        (rd_req),
    .rd_ddr_len_o        (rd_len),
    .rd_ddr_addr_o       (rd_addr),
    .rd_ddr_data_valid_i (rd_valid),
    .rd_ddr_data_i       (rd_data),
    .rd_ddr_finish_i     (rd_finish),
    .len_err_o           (len_err),
    .timeout_o           (tmo)
  );

  typedef struct { logic [3:0] grant; logic [7:0] len; logic [29:0] addr; } gexp_t;
  typedef struct { logic [3:0] vec; logic [255:0] data; } bexp_t;
  typedef struct { logic [3:0] vec; logic len_err; logic tmo; } fexp_t;

  gexp_t gq[$];
  bexp_t bq[$];
  fexp_t fq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int tb_ptr  = 0;
  logic [31:0] beat_seq = 32'h1000_0000;
  logic req_prev = 1'b0;

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin choice: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int i = 0; i < 4; i++)
      if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
    return 0;
  endfunction

  task automatic set_ch(input int ch, input logic [7:0] len, input logic [29:0] addr);
    ch_len[ch*8 +: 8]    = len;
    ch_addr[ch*30 +: 30] = addr;
  endtask

  task automatic expect_grant(input int ch);
    gexp_t g;
    g.grant = 4'(1 << ch);
    g.len   = ch_len[ch*8 +: 8];
    g.addr  = ch_addr[ch*30 +: 30];
    gq.push_back(g);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rd_req) chk_eq("req_wait_expired", rd_req, 1'b1);
  endtask

  // DDR side: one cycle of latency, nbeats beats, then finish (or finish with
  // the last beat when same_cycle). Requesters in drop release on the first beat.
  task automatic ddr_burst(input int ch, input int nbeats, input bit same_cycle,
                           input logic [3:0] drop);
    int    exp_beats;
    bexp_t b;
    fexp_t f;
    exp_beats = (ch_len[ch*8 +: 8] == 8'd0) ? 256 : int'(ch_len[ch*8 +: 8]);
    f.vec     = 4'(1 << ch);
    f.len_err = (nbeats != exp_beats);
    f.tmo     = 1'b0;
    wait_req();
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      rd_data  = {8{beat_seq}};
      beat_seq = beat_seq + 32'd1;
      rd_valid = 1'b1;
      b.vec    = 4'(1 << ch);
      b.data   = rd_data;
      bq.push_back(b);
      if (i == 0) ch_req = ch_req & ~drop;
      if (same_cycle && i == nbeats - 1) begin
        rd_finish = 1'b1;
        fq.push_back(f);
      end
      @(posedge clk); #1;
      if (i == 0) chk_eq("req_drop", rd_req, 1'b0);
    end
    rd_valid = 1'b0;
    if (!same_cycle) begin
      if (nbeats == 0) ch_req = ch_req & ~drop;
      rd_finish = 1'b1;
      fq.push_back(f);
      @(posedge clk); #1;
    end
    rd_finish = 1'b0;
    tb_ptr = (ch + 1) % 4;
  endtask

  // Monitor: pops expectations as the DUT produces grants, beats and finishes
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (rd_req && !req_prev) begin
        if (gq.size() == 0) chk_eq("grant_unexpected", ch_grant, 4'b0);
        else begin
          gexp_t g;
          g = gq.pop_front();
          chk_eq("grant", ch_grant, g.grant);
          chk_eq("rd_len", rd_len, g.len);
          chk_eq("rd_addr", rd_addr, g.addr);
        end
      end
      req_prev = rd_req;
      if (ch_dv != 4'b0) begin
        if (bq.size() == 0) chk_eq("beat_unexpected", ch_dv, 4'b0);
        else begin
          bexp_t b;
          b = bq.pop_front();
          chk_eq("beat_vec", ch_dv, b.vec);
          chk_eq("beat_data", ch_data, b.data);
        end
      end
      if (ch_fin != 4'b0) begin
        if (fq.size() == 0) chk_eq("finish_unexpected", ch_fin, 4'b0);
        else begin
          fexp_t f;
          f = fq.pop_front();
          chk_eq("finish_vec", ch_fin, f.vec);
          chk_eq("len_err", len_err, f.len_err);
          chk_eq("timeout", tmo, f.tmo);
        end
      end else begin
        if (len_err) chk_eq("len_err_stray", len_err, 1'b0);
        if (tmo) chk_eq("timeout_stray", tmo, 1'b0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_grant"}, ch_grant, 4'b0);
    chk_eq({tag, "_req"}, rd_req, 1'b0);
    chk_eq({tag, "_len"}, rd_len, 8'b0);
    chk_eq({tag, "_addr"}, rd_addr, 30'b0);
    chk_eq({tag, "_dv"}, ch_dv, 4'b0);
    chk_eq({tag, "_fin"}, ch_fin, 4'b0);
    chk_eq({tag, "_len_err"}, len_err, 1'b0);
    chk_eq({tag, "_timeout"}, tmo, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb watchdog expired");
  end

  initial begin
    int own;
    #3;
    chk_all_zero("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Round-robin fairness: all four hold requests, 4-beat bursts
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) set_ch(c, 8'd4, 30'(32'h100 * (c + 1)));
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      own = rr_pick(ch_req, tb_ptr);
      expect_grant(own);
      ddr_burst(own, 4, 1'b0, (k == 4) ? 4'b1111 : 4'b0000);
    end

    // Single channel 2, 128 beats, with request-to-command latency check
    @(posedge clk); #1;
    set_ch(2, 8'd128, 30'h0001_2300);
    expect_grant(rr_pick(4'b0100, tb_ptr));
    ch_req = 4'b0100;
    @(negedge clk);
    chk_eq("req_lat0", rd_req, 1'b0);
    @(negedge clk);
    chk_eq("req_lat1", rd_req, 1'b1);
    chk_eq("grant_lat1", ch_grant, 4'b0100);
    ddr_burst(2, 128, 1'b0, 4'b0100);

    // Length mismatch: len 16, only 15 beats returned
    @(posedge clk); #1;
    set_ch(1, 8'd16, 30'h0002_0000);
    expect_grant(rr_pick(4'b0010, tb_ptr));
    ch_req = 4'b0010;
    ddr_burst(1, 15, 1'b0, 4'b0010);

    // Same-cycle first beat and finish in ISSUE, len 1
    @(posedge clk); #1;
    set_ch(3, 8'd1, 30'h0003_0040);
    expect_grant(rr_pick(4'b1000, tb_ptr));
    ch_req = 4'b1000;
    ddr_burst(3, 1, 1'b1, 4'b1000);
    chk_eq("same_cycle_req_low", rd_req, 1'b0);

    // Single requester repeated: len 0 = 256 beats, then len 2
    @(posedge clk); #1;
    set_ch(0, 8'd0, 30'h0004_0000);
    expect_grant(rr_pick(4'b0001, tb_ptr));
    ch_req = 4'b0001;
    ddr_burst(0, 256, 1'b0, 4'b0001);
    @(posedge clk); #1;
    set_ch(0, 8'd2, 30'h0004_1000);
    expect_grant(rr_pick(4'b0001, tb_ptr));
    ch_req = 4'b0001;
    ddr_burst(0, 2, 1'b0, 4'b0001);

    // Reset during beat 40 of a channel-1 burst
    @(posedge clk); #1;
    set_ch(1, 8'd64, 30'h0ABC_0000);
    expect_grant(rr_pick(4'b0010, tb_ptr));
    ch_req = 4'b0010;
    wait_req();
    @(posedge clk); #1;
    for (int i = 1; i < 40; i++) begin
      bexp_t b;
      rd_data  = {8{beat_seq}};
      beat_seq = beat_seq + 32'd1;
      rd_valid = 1'b1;
      b.vec    = 4'b0010;
      b.data   = rd_data;
      bq.push_back(b);
      if (i == 1) ch_req = 4'b0000;
      @(posedge clk); #1;
    end
    rd_data = {8{beat_seq}};
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tb_ptr = 0;

    // After reset the pointer is back at 0: channel 0 beats channel 3
    @(posedge clk); #1;
    set_ch(0, 8'd8, 30'h0005_0000);
    set_ch(3, 8'd8, 30'h0006_0000);
    own = rr_pick(4'b1001, tb_ptr);
    expect_grant(own);
    ch_req = 4'b1001;
    ddr_burst(own, 8, 1'b0, 4'(1 << own));
    own = rr_pick(ch_req, tb_ptr);
    expect_grant(own);
    ddr_burst(own, 8, 1'b0, 4'(1 << own));

`ifdef DDR_RD_TIMEOUT_EN
    // Watchdog: no DDR response, finish + timeout on the 64th open cycle
    begin
      fexp_t f;
      int n;
      @(posedge clk); #1;
      set_ch(2, 8'd4, 30'h0007_0000);
      own = rr_pick(4'b0100, tb_ptr);
      expect_grant(own);
      f.vec = 4'(1 << own); f.len_err = 1'b0; f.tmo = 1'b1;
      fq.push_back(f);
      ch_req = 4'b0100;
      wait_req();
      ch_req = 4'b0000;
      n = 1;
      while (ch_fin == 4'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk_eq("timeout_cycle", n, 64);
      tb_ptr = (own + 1) % 4;
      @(posedge clk); #1;
      expect_grant(rr_pick(4'b0100, tb_ptr));
      ch_req = 4'b0100;
      ddr_burst(2, 4, 1'b0, 4'b0100);
    end
`endif

    repeat (4) @(posedge clk);
    #1;
    chk_eq("grant_queue_empty", gq.size(), 0);
    chk_eq("beat_queue_empty", bq.size(), 0);
    chk_eq("finish_queue_empty", fq.size(), 0);
    chk_eq("idle_grant", ch_grant, 4'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
